// File: rtl/sliced_add_sub_unit.sv
// sliced_add_sub_unit: multi-cycle adder/subtractor, SLICE bits per cycle; optional zero flag via ADDSUB_ZERO_FLAG_EN.
module sliced_add_sub_unit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_initial,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal_op
`ifdef ADDSUB_ZERO_FLAG_EN
  , output logic           zero
`endif
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic carry_q, carry_d, ill_q, ill_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [SLICE:0] sum;
  logic is_sub, last;
  assign is_sub = ALUop == 3'b110;
  assign last = k_q == KW'(NSLICE - 1);
  assign sum = {1'b0, a_q[k_q*SLICE +: SLICE]} + {1'b0, b_q[k_q*SLICE +: SLICE]} + {{SLICE{1'b0}}, carry_q};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ill_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ill_q   <= ill_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb
    state_d = state_q == IDLE ? (in_valid ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  // Datapath: capture on acceptance, one slice per RUN cycle; flags settle on the last slice.
  always_comb begin
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    ill_d   = ill_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b_initial ^ {WIDTH{is_sub}};
      ill_d   = !(ALUop == 3'b010 || is_sub);
      k_d     = '0;
      carry_d = is_sub;
    end else if (state_q == RUN) begin
      res_d[k_q*SLICE +: SLICE] = sum[SLICE-1:0];
      carry_d = sum[SLICE];
      k_d     = last ? k_q : k_q + 1'b1;
      cout_d  = last ? sum[SLICE] : cout_q;
      ovf_d   = last ? (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[SLICE-1] != a_q[WIDTH-1]) : ovf_q;
    end
  end
  always_comb begin
    in_ready   = state_q == IDLE;
    out_valid  = state_q == DONE;
    result     = res_q;
    carry_out  = cout_q;
    overflow   = ovf_q;
    illegal_op = ill_q;
  end
`ifdef ADDSUB_ZERO_FLAG_EN
  assign zero = state_q == DONE && res_q == '0;
`endif
endmodule

// File: tb/tb_sliced_add_sub_unit.sv
// tb_sliced_add_sub_unit: randomized and directed checks of sliced_add_sub_unit against a transaction-level model.
module tb_sliced_add_sub_unit;
  localparam int W = 16;
  localparam int NS = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = 0, b_initial = 0;
  logic [2:0] ALUop = 0;
  logic in_ready, out_valid, carry_out, overflow, illegal_op;
  logic [W-1:0] result;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic zero;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sliced_add_sub_unit #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .b_initial(b_initial), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .illegal_op(illegal_op)
`ifdef ADDSUB_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );
  function automatic logic [18:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
    logic sub, c, o, ill;
    int s;
    logic [W-1:0] r;
    sub = op == 3'b110;
    ill = op != 3'b010 && !sub;
    s = sub ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    r = sub ? x - y : x + y;
    c = sub ? (x >= y) : (int'(x) + int'(y) > 65535);
    o = s > 32767 || s < -32768;
    return {ill, o, c, r};
  endfunction
  logic [1:0] m_state = 0;
  int m_cnt = 0;
  logic [18:0] m_exp = 0;
  always @(posedge clk) begin
    if (!rst_n) m_state <= 0;
    else if (m_state == 0 && in_valid) begin
      m_state <= 1;
      m_cnt   <= NS - 1;
      m_exp   <= ref_op(a, b_initial, ALUop);
    end else if (m_state == 1) begin
      if (m_cnt == 0) m_state <= 2;
      else m_cnt <= m_cnt - 1;
    end else if (m_state == 2 && out_ready) m_state <= 0;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic compare();
    check("in_ready", 32'(in_ready), 32'(m_state == 0));
    check("out_valid", 32'(out_valid), 32'(m_state == 2));
    if (m_state == 2) begin
      check("result", 32'(result), 32'(m_exp[15:0]));
      check("carry_out", 32'(carry_out), 32'(m_exp[16]));
      check("overflow", 32'(overflow), 32'(m_exp[17]));
      check("illegal_op", 32'(illegal_op), 32'(m_exp[18]));
    end
`ifdef ADDSUB_ZERO_FLAG_EN
    check("zero", 32'(zero), 32'(m_state == 2 && m_exp[15:0] == 0));
`endif
  endtask
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_state();
    check("rst in_ready", 32'(in_ready), 1);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst result", 32'(result), 0);
    check("rst carry", 32'(carry_out), 0);
    check("rst ovf", 32'(overflow), 0);
    check("rst ill", 32'(illegal_op), 0);
`ifdef ADDSUB_ZERO_FLAG_EN
    check("rst zero", 32'(zero), 0);
`endif
  endtask
  // Issue one request, scramble inputs while busy, verify latency and literal results, leave it in DONE.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                        input logic [W-1:0] er, input logic ec, input logic eo, input logic ei);
    int n;
    a = x; b_initial = y; ALUop = op; in_valid = 1; out_ready = 0;
    step();
    in_valid = 0; a = W'($urandom); b_initial = W'($urandom); ALUop = 3'($urandom);
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (out_valid) break;
    end
    check("latency", 32'(n), NS);
    check("lit result", 32'(result), 32'(er));
    check("lit carry", 32'(carry_out), 32'(ec));
    check("lit ovf", 32'(overflow), 32'(eo));
    check("lit ill", 32'(illegal_op), 32'(ei));
  endtask
  task automatic release_done();
    out_ready = 1;
    step();
    out_ready = 0;
    check("ready after done", 32'(in_ready), 1);
  endtask
  initial begin
    logic [W-1:0] held;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1;
    step();
    run_op(16'h1234, 16'h0FF1, 3'b010, 16'h2225, 0, 0, 0);
    release_done();
    run_op(16'h0005, 16'h0007, 3'b110, 16'hFFFE, 0, 0, 0);
    release_done();
    run_op(16'h8000, 16'h0001, 3'b110, 16'h7FFF, 1, 1, 0);
    release_done();
    run_op(16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1, 0, 0);
`ifdef ADDSUB_ZERO_FLAG_EN
    check("lit zero", 32'(zero), 1);
`endif
    release_done();
    run_op(16'h0003, 16'h0004, 3'b011, 16'h0007, 0, 0, 1);
    held = result;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = W'($urandom); ALUop = 3'($urandom);
      step();
      check("hold result", 32'(result), 32'(held));
      check("hold in_ready", 32'(in_ready), 0);
      check("hold ill", 32'(illegal_op), 1);
    end
    in_valid = 0;
    release_done();
    run_op(16'h0100, 16'h0001, 3'b110, 16'h00FF, 1, 0, 0);
    release_done();
    a = 16'h7777; b_initial = 16'h1111; ALUop = 3'b010; in_valid = 1;
    step();
    in_valid = 0;
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    check_reset_state();
    run_op(16'h0001, 16'h0001, 3'b010, 16'h0002, 0, 0, 0);
    release_done();
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      in_valid = $urandom_range(0, 1) == 1;
      a = W'($urandom);
      b_initial = W'($urandom);
      ALUop = $urandom_range(0, 3) == 0 ? 3'($urandom) : ($urandom_range(0, 1) == 1 ? 3'b110 : 3'b010);
      out_ready = $urandom_range(0, 2) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
